nibble_input_port: RTL
======================

// Module: nibble_input_port
// PURPOSE
//   Input-port responder for the Nibbler uP's IN instruction: owns the 4 raw
//   pushbuttons, synchronizes and debounces them, latches press events, and answers
//   uP read strobes with a 4-bit nibble; a read clears the latched events.
//   Sits between the board pushbuttons and the uP data bus mux.
// PARAMETERS
//   DB_CYCLES  4  consecutive stable synchronized cycles required to accept a change (>=2)
//   CNT_W      3  debounce counter width; must satisfy 2**CNT_W > DB_CYCLES-1
//   STICKY     1  1: data_out = latched press flags; 0: data_out = live debounced levels
// PORTS
//   clock       in   1  system clock, all state on rising edge
//   reset       in   1  synchronous, active-high; clears all state
//   buttons_raw in   4  asynchronous raw pushbutton levels, 1 = pressed
//   rd_en       in   1  uP decoder asserts while executing IN
//   phase       in   1  uP phase; read strobe = rd_en & phase
//   data_out    out  4  nibble to uP data bus; 4'b0000 when not strobed
//   data_oe     out  1  = rd_en & phase (combinational)
//   pending     out  1  = |flag (registered flags, no extra latency)
//   overrun     out  4  per bit: press lost because flag was already set, unread
// BEHAVIOUR
//   Reset: sync1, sync2, db, cnt, flag, overrun = 0; so data_out=0, data_oe=0 while
//     rd_en&phase=0, pending=0, overrun=0.
//   Sync: 2-FF chain per bit, buttons_raw -> sync1 -> sync2.
//   Debounce, per bit i:
//     - sync2==db: cnt<=0.
//     - sync2!=db and cnt<DB_CYCLES-1: cnt<=cnt+1.
//     - sync2!=db and cnt==DB_CYCLES-1: db<=sync2, cnt<=0.
//     - Latency raw edge -> db change = 2+DB_CYCLES clock edges.
//     - Glitch shorter than DB_CYCLES synchronized cycles: no db change, cnt returns to 0.
//   rise[i] (combinational): accepted 0->1 update this cycle. The release (1->0) is
//     debounced the same way but sets nothing.
//   Read strobe rs = rd_en & phase. Each cycle with rs=1 is one read; held rd_en with
//     phase=1 for N cycles gives N reads.
//   data_out = rs ? (STICKY ? flag : db) : 4'b0000. Reflects pre-edge register values.
//   Flag update: flag <= (flag & ~{4{rs}}) | rise. Set wins over clear, so a press
//     coinciding with a read is returned by the NEXT read.
//   Overrun update: overrun <= (overrun & ~{4{rs}}) | (rise & flag & ~{4{rs}}).
//     A rise on an unread set flag sets overrun. A rise during a read does not.
//   STICKY=0: flag/overrun still maintained; only the data_out source changes.
//   Reset mid-debounce: counter is discarded. A button held through reset is re-accepted
//     2+DB_CYCLES edges after reset deasserts and sets its flag.
//   No combinational path from buttons_raw to any output.
// TESTING
//   T1 reset=1, buttons_raw=4'b1111 for 3 cycles
//      -> data_out=0, pending=0, overrun=0; release reset, hold 1111
//      -> flag=1111 after edge 6.
//   T2 buttons_raw 0000->0100 held (DB_CYCLES=4)
//      -> db[2]=1 and pending=1 exactly after edge 6; 1 edge earlier pending=0.
//   T3 bounce: bit1 high for 2 cycles, low for 1, high for 2, then low
//      -> db/flag/pending never change.
//   T4 after T2, rd_en=1 phase=1 one cycle
//      -> data_out=4'b0100, data_oe=1; next cycle pending=0; rd_en=1 phase=0
//      -> data_out=0, data_oe=0.
//   T5 rise on bit0 in same cycle as read with flag=0
//      -> data_out=4'b0000, flag[0]=1 after edge; second read
//      -> data_out=4'b0001.
//   T6 two debounced presses on bit3, no read
//      -> overrun=4'b1000; read -> data_out=4'b1000, then flag=0, overrun=0.
//      STICKY=0 variant: bit3 held, read -> data_out=4'b1000.

Source files
------------

// File: rtl/nibble_input_port.sv
// Pushbutton input port for the Nibbler IN instruction: synchronizes and debounces four
// buttons, latches press events, and returns them on a uP read strobe (reads clear them).
module nibble_input_port #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 3,
    parameter int STICKY    = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] buttons_raw,
    input  logic       rd_en,
    input  logic       phase,
    output logic [3:0] data_out,
    output logic       data_oe,
    output logic       pending,
    output logic [3:0] overrun
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_db;
    logic [CNT_W-1:0] r_cnt [4];
    logic [3:0]       r_flag;
    logic [3:0]       r_overrun;

    logic             w_rs;
    logic [3:0]       w_rise;
    logic [3:0]       w_rs4;

    assign w_rs  = rd_en & phase;
    assign w_rs4 = {4{w_rs}};

    // A rise is the cycle a held 0->1 difference is finally accepted into r_db.
    always_comb begin
        w_rise = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            w_rise[i] = r_sync2[i] & ~r_db[i] & (r_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1   <= 4'b0000;
            r_sync2   <= 4'b0000;
            r_db      <= 4'b0000;
            r_flag    <= 4'b0000;
            r_overrun <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= buttons_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_db[i]  <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end
            end
            // Set wins over the read clear, so a press racing a read survives to the next read.
            r_flag    <= (r_flag & ~w_rs4) | w_rise;
            r_overrun <= (r_overrun & ~w_rs4) | (w_rise & r_flag & ~w_rs4);
        end
    end

    always_comb begin
        data_out = 4'b0000;
        if (w_rs) begin
            data_out = (STICKY != 0) ? r_flag : r_db;
        end
    end

    assign data_oe = w_rs;
    assign pending = |r_flag;
    assign overrun = r_overrun;

endmodule
